// File: rtl/elastic_pipeline_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer; drives NOP_DATA when empty.
// Define PIPE_STAGE_STATS_EN to add saturating stall/bubble statistics counters.
module elastic_pipeline_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] NOP_DATA = WIDTH'(32'h00000013),
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_stall,
  output logic [CNT_W-1:0] stat_bubble
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The encoding equals the number of live entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_acc;
  logic             w_pop;

  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = out_valid ? r_main : NOP_DATA;
  assign occupancy = r_state;

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_acc) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_acc && !w_pop)      r_state <= ST_FULL;
          else if (!w_acc && w_pop) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_pop) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  // Payload registers carry no reset: out_data is masked to NOP_DATA while empty.
  always_ff @(posedge clk) begin
    case (r_state)
      ST_EMPTY: if (w_acc) r_main <= in_data;
      ST_ONE: begin
        if (w_acc && w_pop)  r_main <= in_data;
        if (w_acc && !w_pop) r_skid <= in_data;
      end
      ST_FULL:  if (w_pop) r_main <= r_skid;
      default:  ;
    endcase
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] r_stat_stall;
  logic [CNT_W-1:0] r_stat_bubble;

  // Counters saturate at all-ones and survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_stall  <= '0;
      r_stat_bubble <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + CNT_W'(1);
      if (!out_valid && (r_stat_bubble != '1))
        r_stat_bubble <= r_stat_bubble + CNT_W'(1);
    end
  end

  assign stat_stall  = r_stat_stall;
  assign stat_bubble = r_stat_bubble;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_elastic_pipeline_stage.sv
// Scoreboard bench for elastic_pipeline_stage: directed scenarios plus a long random run.
// Exercises the statistics counters (CNT_W=4) when PIPE_STAGE_STATS_EN is defined.
module tb_elastic_pipeline_stage;
  localparam int          WIDTH = 32;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef PIPE_STAGE_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stat_stall;
  logic [CNT_W-1:0] stat_bubble;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_bubble;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  elastic_pipeline_stage #(
    .WIDTH(WIDTH), .NOP_DATA(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stat_stall(stat_stall), .stat_bubble(stat_bubble)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver: one cycle of stimulus; outputs checked against the model, then model advanced.
  task automatic step(input logic rst_n, input logic iv, input logic [WIDTH-1:0] id,
                      input logic ordy, input logic fl);
    int  n;
    logic acc, pop;
    @(negedge clk);
    rst = rst_n; in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    n = exp_q.size();
    check_eq("occupancy", 32'(occupancy), 32'(n));
    check_eq("out_valid", 32'(out_valid), 32'(n != 0));
    check_eq("in_ready",  32'(in_ready),  32'(n != 2));
    check_eq("out_data",  out_data, (n != 0) ? exp_q[0] : NOP);
`ifdef PIPE_STAGE_STATS_EN
    check_eq("stat_stall",  32'(stat_stall),  32'(exp_stall));
    check_eq("stat_bubble", 32'(stat_bubble), 32'(exp_bubble));
    if (!rst_n) begin
      exp_stall  = '0;
      exp_bubble = '0;
    end else begin
      if (n != 0 && !ordy && exp_stall != '1) exp_stall++;
      if (n == 0 && exp_bubble != '1) exp_bubble++;
    end
`endif
    pop = (n != 0) && ordy;
    acc = iv && (n != 2);
    if (!rst_n || fl) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(id);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
    exp_stall = '0; exp_bubble = '0;
`endif
    repeat (2) @(posedge clk);
    step(1'b0, 1'b1, 32'h99, 1'b0, 1'b0);   // reset held: offer ignored

    // Back-to-back stream with free downstream
    step(1'b1, 1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h3, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Fill to FULL under backpressure, then drain in order
    step(1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hE, 1'b0, 1'b0);   // refused while FULL
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while FULL with a simultaneous offer
    step(1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hC, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset while FULL, then a single transfer
    step(1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Reset dominates flush
    step(1'b1, 1'b1, 32'h6, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h7, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

`ifdef PIPE_STAGE_STATS_EN
    // Stall counter saturation; flush must not clear it
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h7, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("stat_stall_saturated", 32'(stat_stall), 32'd15);
`endif

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 511) != 0),
           1'($urandom_range(0, 1)),
           $urandom,
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0));
    end
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
